// File: rtl/sr_latch_bank_ctrl.sv
// Round-robin sequencer for a bank of 2**IDX_W gated SR latches, with a registered shadow of the latch states.
// Optional macro SR_CONFLICT_CHECK_EN: s=r=1 commands are rejected and flagged on a sticky err output.
module sr_latch_bank_ctrl #(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = 2,
    parameter int EN_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         cmd_s,
    input  logic [N_REQ-1:0]         cmd_r,
    input  logic [N_REQ*IDX_W-1:0]   cmd_idx,
    output logic [N_REQ-1:0]         ack,
    output logic                     busy,
    output logic                     lat_s,
    output logic                     lat_r,
    output logic [(2**IDX_W)-1:0]    lat_e,
    output logic [(2**IDX_W)-1:0]    flags
`ifdef SR_CONFLICT_CHECK_EN
    ,
    output logic                     err
`endif
);
    localparam int N_FLAGS = 2**IDX_W;
    localparam int PTR_W   = $clog2(N_REQ);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ACK} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_FLAGS-1:0] flags_q, flags_d;
`ifdef SR_CONFLICT_CHECK_EN
    logic               err_q, err_d;
`endif

    logic [N_REQ-1:0]   rot;
    logic [PTR_W:0]     sum;
    logic [PTR_W-1:0]   sel;
    logic               found;
    logic               sel_s, sel_r;
    logic [IDX_W-1:0]   sel_idx;

    // Rotate requests so bit 0 is the pointer; the lowest set bit wins.
    always_comb begin
        rot   = N_REQ'({req, req} >> ptr_q);
        found = |req;
        sum   = '0;
        sel   = ptr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
                if (sum >= (PTR_W+1)'(N_REQ)) begin
                    sum = sum - (PTR_W+1)'(N_REQ);
                end
                sel = sum[PTR_W-1:0];
            end
        end
        sel_s   = 1'b0;
        sel_r   = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel == PTR_W'(i)) begin
                sel_s   = cmd_s[i];
                sel_r   = cmd_r[i];
                sel_idx = cmd_idx[i*IDX_W +: IDX_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        r_d     = r_q;
        idx_d   = idx_q;
        flags_d = flags_q;
`ifdef SR_CONFLICT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    s_d     = sel_s;
                    r_d     = sel_r;
                    idx_d   = sel_idx;
                    state_d = SETUP;
`ifdef SR_CONFLICT_CHECK_EN
                    if (sel_s && sel_r) begin
                        state_d = ACK;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            SETUP: begin
                cnt_d   = 4'(EN_CYCLES - 1);
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                // Set-dominant: s wins, r clears, 00 leaves the shadow alone.
                for (int i = 0; i < N_FLAGS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        flags_d[i] = s_q | (flags_q[i] & ~r_q);
                    end
                end
                state_d = ACK;
            end
            ACK: begin
                ptr_d   = (gnt_q == PTR_W'(N_REQ - 1)) ? '0 : gnt_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ack   = '0;
        lat_e = '0;
        lat_s = 1'b0;
        lat_r = 1'b0;
        busy  = (state_q != IDLE);
        if (state_q == SETUP || state_q == PULSE || state_q == HOLD) begin
            lat_s = s_q;
            lat_r = r_q;
        end
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (state_q == ACK) && (gnt_q == PTR_W'(i));
        end
        for (int i = 0; i < N_FLAGS; i++) begin
            lat_e[i] = (state_q == PULSE) && (idx_q == IDX_W'(i));
        end
        flags = flags_q;
    end

`ifdef SR_CONFLICT_CHECK_EN
    assign err = err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            flags_q <= '0;
`ifdef SR_CONFLICT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            flags_q <= flags_d;
`ifdef SR_CONFLICT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Captured command is only observed while the FSM is busy, so it needs no reset.
    always_ff @(posedge clk) begin
        gnt_q <= gnt_d;
        s_q   <= s_d;
        r_q   <= r_d;
        idx_q <= idx_d;
    end

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Directed bench for sr_latch_bank_ctrl: a cycle-offset transaction model checked every cycle plus literal spot checks.
module tb_sr_latch_bank_ctrl;
    localparam int N_REQ     = 4;
    localparam int IDX_W     = 2;
    localparam int EN_CYCLES = 2;
    localparam int HOLD_T    = 2 + EN_CYCLES;
    localparam int ACK_T     = 3 + EN_CYCLES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] cmd_s = '0;
    logic [3:0] cmd_r = '0;
    logic [7:0] cmd_idx = '0;
    logic [3:0] ack;
    logic       busy;
    logic       lat_s;
    logic       lat_r;
    logic [3:0] lat_e;
    logic [3:0] flags;
`ifdef SR_CONFLICT_CHECK_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sr_latch_bank_ctrl #(.N_REQ(N_REQ), .IDX_W(IDX_W), .EN_CYCLES(EN_CYCLES)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r), .cmd_idx(cmd_idx),
        .ack(ack), .busy(busy), .lat_s(lat_s), .lat_r(lat_r), .lat_e(lat_e), .flags(flags)
`ifdef SR_CONFLICT_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the cycle offset since capture (0 = idle).
    int         m_t = 0;
    int         m_gnt = 0;
    int         m_ptr = 0;
    int         m_idx = 0;
    int         m_j;
    logic       m_s = 1'b0;
    logic       m_r = 1'b0;
    logic [3:0] m_flags = '0;
    logic       m_err = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_ptr = 0; m_flags = '0; m_err = 1'b0;
        end else if (m_t == 0) begin
            for (int k = 0; k < N_REQ; k++) begin
                m_j = (m_ptr + k) % N_REQ;
                if (m_t == 0 && req[m_j]) begin
                    m_gnt = m_j;
                    m_s   = cmd_s[m_j];
                    m_r   = cmd_r[m_j];
                    m_idx = int'(cmd_idx[m_j*IDX_W +: IDX_W]);
                    m_t   = 1;
                end
            end
`ifdef SR_CONFLICT_CHECK_EN
            if (m_t == 1 && m_s && m_r) begin
                m_t = ACK_T;
                m_err = 1'b1;
            end
`endif
        end else if (m_t == HOLD_T) begin
            if (m_s) m_flags[m_idx] = 1'b1;
            else if (m_r) m_flags[m_idx] = 1'b0;
            m_t++;
        end else if (m_t == ACK_T) begin
            m_ptr = (m_gnt + 1) % N_REQ;
            m_t = 0;
        end else begin
            m_t++;
        end
    end

    logic [3:0] e_lat_e, e_ack;
    logic       e_drive;

    always @(negedge clk) begin
        e_drive = (m_t >= 1 && m_t <= HOLD_T);
        e_lat_e = (m_t >= 2 && m_t <= 1 + EN_CYCLES) ? (4'b0001 << m_idx) : 4'b0000;
        e_ack   = (m_t == ACK_T) ? (4'b0001 << m_gnt) : 4'b0000;
        check("model_busy",  32'(busy),  32'(m_t != 0));
        check("model_lat_s", 32'(lat_s), 32'(e_drive & m_s));
        check("model_lat_r", 32'(lat_r), 32'(e_drive & m_r));
        check("model_lat_e", 32'(lat_e), 32'(e_lat_e));
        check("model_ack",   32'(ack),   32'(e_ack));
        check("model_flags", 32'(flags), 32'(m_flags));
        check("lat_e_excl",  32'($countones(lat_e) <= 1), 32'(1));
`ifdef SR_CONFLICT_CHECK_EN
        check("model_err",   32'(err),   32'(m_err));
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cmd(input int i, input logic s, input logic r, input logic [1:0] idx);
        cmd_s[i] = s;
        cmd_r[i] = r;
        cmd_idx[i*IDX_W +: IDX_W] = idx;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    int ord[4];
    int tim[4];
    int n_ack;

    initial begin
        tick(2);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_lat_e", 32'(lat_e), 32'h0);
        rst = 1'b0;

        // Set idx 2
        set_cmd(0, 1'b1, 1'b0, 2'd2);
        req[0] = 1'b1;
        tick(1);
        check("t1_setup_busy", 32'(busy), 32'h1);
        check("t1_setup_lat_e", 32'(lat_e), 32'h0);
        tick(1);
        check("t1_pulse0_lat_e", 32'(lat_e), 32'h4);
        tick(1);
        check("t1_pulse1_lat_e", 32'(lat_e), 32'h4);
        tick(1);
        check("t1_hold_lat_e", 32'(lat_e), 32'h0);
        tick(1);
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_flags", 32'(flags), 32'h4);
        req[0] = 1'b0;
        tick(1);

        // Reset idx 2
        set_cmd(0, 1'b0, 1'b1, 2'd2);
        req[0] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick(1);
            check("t2_lat_r", 32'(lat_r), 32'h1);
            check("t2_lat_s", 32'(lat_s), 32'h0);
        end
        tick(1);
        check("t2_ack", 32'(ack), 32'h1);
        check("t2_flags", 32'(flags), 32'h0);
        req[0] = 1'b0;

        // All four requesters contend
        pulse_reset();
        for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 1'b0, 2'(i));
        req = 4'hF;
        n_ack = 0;
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            tick(1);
            for (int i = 0; i < 4; i++) begin
                if (ack[i] && n_ack < 4) begin
                    ord[n_ack] = i;
                    tim[n_ack] = c;
                    n_ack++;
                    req[i] = 1'b0;
                end
            end
        end
        req = '0;
        check("t3_ack_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) begin
                check("t3_ack_order", 32'(ord[k]), 32'(k));
                check("t3_ack_time", 32'(tim[k]), 32'(5 + 6 * k));
            end
        end
        check("t3_flags", 32'(flags), 32'hF);
        tick(1);

        // s=r=1 on requester 1
        pulse_reset();
        set_cmd(1, 1'b1, 1'b1, 2'd1);
        req[1] = 1'b1;
`ifdef SR_CONFLICT_CHECK_EN
        tick(1);
        check("t4_ack_fast", 32'(ack), 32'h2);
        check("t4_lat_e", 32'(lat_e), 32'h0);
        req[1] = 1'b0;
        tick(1);
        check("t4_err", 32'(err), 32'h1);
        check("t4_flags", 32'(flags), 32'h0);
        check("t4_idle", 32'(busy), 32'h0);
`else
        tick(5);
        check("t4_ack", 32'(ack), 32'h2);
        check("t4_flags", 32'(flags), 32'h2);
        req[1] = 1'b0;
        tick(1);
`endif

        // Reset during PULSE
        set_cmd(3, 1'b1, 1'b0, 2'd3);
        req[3] = 1'b1;
        tick(2);
        check("t5_pulse_lat_e", 32'(lat_e), 32'h8);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_lat_e", 32'(lat_e), 32'h0);
        check("t5_rst_ack", 32'(ack), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_flags", 32'(flags), 32'h0);
        req = '0;
        tick(1);
        rst = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 2'd0);
        req = 4'b1001;
        tick(5);
        check("t5_ptr0_ack", 32'(ack), 32'h1);
        req[0] = 1'b0;
        tick(6);
        check("t5_next_ack", 32'(ack), 32'h8);
        req = '0;
        tick(1);

        // Drop req and change idx after capture
        set_cmd(2, 1'b1, 1'b0, 2'd1);
        req[2] = 1'b1;
        tick(1);
        req[2] = 1'b0;
        set_cmd(2, 1'b0, 1'b0, 2'd3);
        tick(1);
        check("t6_lat_e", 32'(lat_e), 32'h2);
        tick(3);
        check("t6_ack", 32'(ack), 32'h4);
        tick(1);
        check("t6_flags", 32'(flags), 32'hB);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sr_latch_bank_ctrl.md
Name: sr_latch_bank_ctrl

Overview:
- Sequencer and round-robin arbiter for a bank of 2**IDX_W gated SR latches with level enables.
- Shares the bank between N_REQ requesters.
- Per granted command, drives the latch set/reset inputs with setup and hold margin around a multi-cycle enable pulse.
- Keeps a registered shadow copy of every latch state for readback.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- IDX_W, 2: latch index width; bank size N_FLAGS = 2**IDX_W.
- EN_CYCLES, 2: width of the enable pulse in clocks (1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N_REQ  per-requester command request; held until ack.
- cmd_s  input  N_REQ  per-requester set bit.
- cmd_r  input  N_REQ  per-requester reset bit.
- cmd_idx  input  N_REQ*IDX_W  per-requester target latch; requester i uses bits [i*IDX_W +: IDX_W].
- ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever the FSM is not in IDLE.
- lat_s  output  1  set line to the latch bank.
- lat_r  output  1  reset line to the latch bank.
- lat_e  output  N_FLAGS  one-hot enable to the latch bank.
- flags  output  N_FLAGS  shadow of the latch states.
- err  output  1  sticky conflict flag; exists only with SR_CONFLICT_CHECK_EN.

Behaviour:
- Reset (asynchronous, immediate): FSM to IDLE; ack, busy, lat_s, lat_r, lat_e, flags, err all 0; round-robin pointer 0, so requester 0 has highest priority first.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> ACK -> IDLE.
- IDLE:
  - If any req is high, select the first requester at or after the pointer, wrapping modulo N_REQ.
  - Register that requester's cmd_s, cmd_r and cmd_idx, then go to SETUP.
  - With no req, stay in IDLE.
- SETUP (1 cycle): lat_s/lat_r driven from the captured command; lat_e all 0.
- PULSE (EN_CYCLES cycles): lat_e[idx] = 1, all other enable bits 0; lat_s/lat_r held. Cycle count kept by a 4-bit down-counter.
- HOLD (1 cycle): lat_e all 0; lat_s/lat_r held.
  - Shadow update on this cycle: s=1 -> flags[idx] = 1 (s=r=1 is set-dominant); s=0,r=1 -> 0; s=0,r=0 -> unchanged.
  - A 00 command still runs the full sequence.
- ACK (1 cycle):
  - ack[granted] = 1; lat_s/lat_r return to 0.
  - Pointer becomes granted+1 (mod N_REQ).
  - Next state is IDLE.
- Latency: request sampled in IDLE at cycle 0 -> ack at cycle 3+EN_CYCLES. Minimum spacing between grants is 4+EN_CYCLES cycles.
- Only the captured command is used. Changes to cmd_* or req after capture are ignored. A req dropped mid-sequence still completes and still receives ack.
- Requester handshake: after ack, the requester deasserts req or presents a new command on the next cycle. If req stays high, it is a new request arbitrated normally; rotation applies, so it does not win again while others wait.
- Grants are exclusive: at most one lat_e bit and at most one ack bit high in any cycle.
- Reset mid-sequence: lat_e drops asynchronously and no ack is issued. The latch bank content is indeterminate for the interrupted index; flags reads 0.
- busy = 1 in SETUP, PULSE, HOLD and ACK.

Optional Feature:
- Macro: SR_CONFLICT_CHECK_EN.
- Defined:
  - A captured command with s=r=1 skips SETUP, PULSE and HOLD: IDLE -> ACK directly.
  - No enable is driven and flags are unchanged.
  - err is set and stays set until rst.
- Not defined:
  - s=r=1 is executed as set-dominant (flags[idx] = 1).
  - The err port is absent.

Test Plan:
- Reset, then req[0]=1, s=1, r=0, idx=2, EN_CYCLES=2 -> lat_e=4'b0100 on cycles 2-3; ack[0] on cycle 5; flags=4'b0100.
- Follow with req[0], s=0, r=1, idx=2 -> flags returns to 4'b0000; lat_r high from SETUP through HOLD; lat_s stays 0.
- All four req held high with distinct idx 0..3, s=1 -> acks arrive in order 0,1,2,3, spaced 6 cycles apart; flags=4'b1111; never two lat_e bits high at once.
- req[1] with s=r=1, idx=1:
  - Macro off -> flags[1]=1, err absent.
  - Macro on -> lat_e stays 0, ack[1] at cycle 1, flags[1] unchanged, err=1.
- Assert rst during PULSE of an idx=3 set -> lat_e=0 the same cycle, no ack, flags=0, FSM in IDLE, pointer 0.
- req[2] dropped one cycle after capture, with cmd_idx changed -> the original idx is still enabled and ack[2] still pulses at cycle 3+EN_CYCLES.
